dmg_clk_phase_monitor: RTL and testbench
========================================

// Module: dmg_clk_phase_monitor
// PURPOSE
// - Receiving end of the external clock generator's phase interface: samples MAIN/DATA/INC/ADR phase clocks,
//   OSC_STABLE and SYNC_RESET on CLK and recovers the CPU T-state.
// - Checks every M-cycle for legal phase sequencing and reports lock and sticky error flags.
// - Sits beside the CPU core in sim/FPGA builds as a clock-integrity checker.
// PARAMETERS
// - MCYCLE_LEN   4   CLK samples per M-cycle (2..7)
// - LOCK_CYCLES  2   consecutive good M-cycles required to assert LOCKED (1..7)
// - CNT_W        16  width of MCYCLE_CNT
// PORTS
// - CLK          in   1      oscillator clock; all sampling on posedge
// - nRESET       in   1      asynchronous, active-low reset
// - MAIN_CLK_P   in   1      M-cycle boundary phase; its rising edge starts an M-cycle
// - DATA_CLK_P   in   1      CPU_PHI phase
// - INC_CLK_P    in   1      CPU_T4 phase
// - ADR_CLK_P    in   1      DATA_VALID phase
// - ADR_CLK_N    in   1      complement of ADR_CLK_P
// - CLK_ENA      in   1      1 = phase clocks running; 0 = clocks stopped, monitor freezes
// - OSC_STABLE   in   1      oscillator stable
// - SYNC_RESET   in   1      1 = CPU held in sync reset
// - ERR_CLR      in   1      synchronous clear of sticky error flags
// - LOCKED       out  1      phase tracking locked
// - T_STATE      out  2      ph[1:0] while LOCKED, else 0
// - ERR_PERIOD   out  1      sticky: M-cycle length != MCYCLE_LEN
// - ERR_DATA     out  1      sticky: DATA_CLK_P rises != 1 per M-cycle
// - ERR_INC      out  1      sticky: INC_CLK_P rises != 1 per M-cycle
// - ERR_ADR      out  1      sticky: ADR_CLK_P == ADR_CLK_N
// - MCYCLE_CNT   out  CNT_W  good M-cycles counted while locked
// BEHAVIOUR
// - nRESET=0: state IDLE; all outputs, prev-sample regs, ph and rise counters = 0.
// - Edge detect: rise(x) = x & ~x_prev; x_prev updates every CLK.
// - ph: 3-bit, set 0 on the MAIN rise sample, else +1, saturating at 7.
// - d_cnt, i_cnt: 2-bit saturating rise counters. On a MAIN rise sample: reload with that sample's rise (0/1).
// - Good M-cycle, evaluated at each MAIN rise: ph==MCYCLE_LEN-1 && d_cnt==1 && i_cnt==1 && no ADR fault in that cycle.
// - Any state: OSC_STABLE=0 or SYNC_RESET=1 -> IDLE next CLK. Priority over all else.
// - IDLE -> ACQ when OSC_STABLE=1 & SYNC_RESET=0. IDLE clears MCYCLE_CNT.
// - ACQ -> SYNC on first MAIN rise; good counter g=0; no checks run in ACQ.
// - SYNC: per MAIN rise, good -> g+1, bad -> g=0, set matching flag(s). At g==LOCK_CYCLES -> LOCK.
// - LOCK: bad M-cycle -> SYNC, g=0, set flag(s); LOCKED falls on the same CLK edge.
// - ERR_ADR checked on every SYNC/LOCK sample with CLK_ENA=1; it sets the flag on the next edge and marks the cycle bad.
// - CLK_ENA=0: state, ph, g, rise counters and MCYCLE_CNT hold; no checks. Resume on CLK_ENA=1 without relock.
// - Flags: sticky, only set in SYNC/LOCK. ERR_CLR=1 clears them; a set on the same edge wins.
// - All outputs registered; 1-CLK latency from the offending sample.
// CONFIGURATION
// - DMG_CLKMON_MCNT_EN defined: MCYCLE_CNT += 1 per good M-cycle in LOCK, wraps modulo 2^CNT_W.
// - Not defined: counter not built; MCYCLE_CNT tied to 0.
// TESTING
// - nRESET=0 with random inputs -> all outputs 0; release with OSC_STABLE=0 -> stays IDLE, LOCKED=0.
// - Clean pattern, period 4, defaults -> LOCKED=1 one CLK after the 3rd MAIN rise; T_STATE cycles 0,1,2,3; no flags.
// - Stretch one locked M-cycle to 5 samples -> ERR_PERIOD=1, LOCKED=0; relock after 2 good cycles; flag held until ERR_CLR.
// - Drop the DATA_CLK_P pulse in one cycle -> ERR_DATA=1; double INC_CLK_P pulse -> ERR_INC=1; other flags stay 0.
// - ADR_CLK_P=ADR_CLK_N=1 for one sample -> ERR_ADR=1 next edge; ERR_CLR and fault on the same edge -> flag stays 1.
// - Locked, CLK_ENA=0 for 10 CLK -> LOCKED, T_STATE and MCYCLE_CNT frozen; OSC_STABLE=0 -> IDLE, MCYCLE_CNT=0.
// - MCNT_EN defined, CNT_W=4: after 16 good locked cycles -> MCYCLE_CNT wraps to 0.

Source files
------------

// File: rtl/dmg_clk_phase_monitor.sv
// ============================================================================
// dmg_clk_phase_monitor: phase-clock integrity checker and CPU T-state recovery.
// Optional good-M-cycle counter enabled by DMG_CLKMON_MCNT_EN.      Rev 1.0
// ============================================================================
`default_nettype none

module dmg_clk_phase_monitor #(
  parameter int MCYCLE_LEN  = 4,
  parameter int LOCK_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             MAIN_CLK_P,
  input  logic             DATA_CLK_P,
  input  logic             INC_CLK_P,
  input  logic             ADR_CLK_P,
  input  logic             ADR_CLK_N,
  input  logic             CLK_ENA,
  input  logic             OSC_STABLE,
  input  logic             SYNC_RESET,
  input  logic             ERR_CLR,
  output logic             LOCKED,
  output logic [1:0]       T_STATE,
  output logic             ERR_PERIOD,
  output logic             ERR_DATA,
  output logic             ERR_INC,
  output logic             ERR_ADR,
  output logic [CNT_W-1:0] MCYCLE_CNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_SYNC = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  localparam logic [2:0] PH_LAST = 3'(MCYCLE_LEN - 1);
  localparam logic [2:0] LOCK_G  = 3'(LOCK_CYCLES);

  logic [1:0] state_q, state_d;
  logic       main_prev_q, main_prev_d;
  logic       data_prev_q, data_prev_d;
  logic       inc_prev_q, inc_prev_d;
  logic [2:0] ph_q, ph_d;
  logic [1:0] d_cnt_q, d_cnt_d;
  logic [1:0] i_cnt_q, i_cnt_d;
  logic       adr_bad_q, adr_bad_d;
  logic [2:0] g_q, g_d;
  logic       locked_q, locked_d;
  logic [1:0] t_state_q, t_state_d;
  logic       err_period_q, err_period_d;
  logic       err_data_q, err_data_d;
  logic       err_inc_q, err_inc_d;
  logic       err_adr_q, err_adr_d;

  logic main_rise, data_rise, inc_rise;
  logic abort, checking, adr_fault, good, eval, eval_bad;

  assign main_rise = MAIN_CLK_P & ~main_prev_q;
  assign data_rise = DATA_CLK_P & ~data_prev_q;
  assign inc_rise  = INC_CLK_P  & ~inc_prev_q;
  assign abort     = ~OSC_STABLE | SYNC_RESET;
  assign checking  = CLK_ENA & ~abort & ((state_q == S_SYNC) | (state_q == S_LOCK));
  assign adr_fault = (ADR_CLK_P == ADR_CLK_N);
  assign good      = (ph_q == PH_LAST) & (d_cnt_q == 2'd1) & (i_cnt_q == 2'd1) & ~adr_bad_q;
  // A checked M-cycle closes on the MAIN rise sample that opens the next one.
  assign eval      = checking & main_rise;
  assign eval_bad  = eval & ~good;

  always_comb begin
    state_d     = state_q;
    main_prev_d = MAIN_CLK_P;
    data_prev_d = DATA_CLK_P;
    inc_prev_d  = INC_CLK_P;
    ph_d        = ph_q;
    d_cnt_d     = d_cnt_q;
    i_cnt_d     = i_cnt_q;
    adr_bad_d   = adr_bad_q;
    g_d         = g_q;

    if (CLK_ENA) begin
      if (main_rise) begin
        ph_d      = 3'd0;
        d_cnt_d   = {1'b0, data_rise};
        i_cnt_d   = {1'b0, inc_rise};
        adr_bad_d = checking & adr_fault;
      end else begin
        ph_d      = (ph_q == 3'd7) ? 3'd7 : ph_q + 3'd1;
        d_cnt_d   = (d_cnt_q == 2'd3) ? 2'd3 : d_cnt_q + {1'b0, data_rise};
        i_cnt_d   = (i_cnt_q == 2'd3) ? 2'd3 : i_cnt_q + {1'b0, inc_rise};
        adr_bad_d = adr_bad_q | (checking & adr_fault);
      end
    end

    if (abort) begin
      state_d = S_IDLE;
      g_d     = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ACQ;
        S_ACQ: begin
          if (CLK_ENA && main_rise) begin
            state_d = S_SYNC;
            g_d     = 3'd0;
          end
        end
        S_SYNC: begin
          if (eval) begin
            if (good) begin
              g_d = g_q + 3'd1;
              if (g_d == LOCK_G) state_d = S_LOCK;
            end else begin
              g_d = 3'd0;
            end
          end
        end
        default: begin
          if (eval_bad) begin
            state_d = S_SYNC;
            g_d     = 3'd0;
          end
        end
      endcase
    end

    // A flag set on this edge overrides a simultaneous clear.
    err_period_d = (eval_bad & (ph_q != PH_LAST))    | (err_period_q & ~ERR_CLR);
    err_data_d   = (eval_bad & (d_cnt_q != 2'd1))    | (err_data_q   & ~ERR_CLR);
    err_inc_d    = (eval_bad & (i_cnt_q != 2'd1))    | (err_inc_q    & ~ERR_CLR);
    err_adr_d    = (checking & adr_fault)            | (err_adr_q    & ~ERR_CLR);

    locked_d  = (state_d == S_LOCK);
    t_state_d = locked_d ? ph_d[1:0] : 2'b00;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= S_IDLE;
      main_prev_q  <= 1'b0;
      data_prev_q  <= 1'b0;
      inc_prev_q   <= 1'b0;
      ph_q         <= 3'd0;
      d_cnt_q      <= 2'd0;
      i_cnt_q      <= 2'd0;
      adr_bad_q    <= 1'b0;
      g_q          <= 3'd0;
      locked_q     <= 1'b0;
      t_state_q    <= 2'd0;
      err_period_q <= 1'b0;
      err_data_q   <= 1'b0;
      err_inc_q    <= 1'b0;
      err_adr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_prev_q  <= main_prev_d;
      data_prev_q  <= data_prev_d;
      inc_prev_q   <= inc_prev_d;
      ph_q         <= ph_d;
      d_cnt_q      <= d_cnt_d;
      i_cnt_q      <= i_cnt_d;
      adr_bad_q    <= adr_bad_d;
      g_q          <= g_d;
      locked_q     <= locked_d;
      t_state_q    <= t_state_d;
      err_period_q <= err_period_d;
      err_data_q   <= err_data_d;
      err_inc_q    <= err_inc_d;
      err_adr_q    <= err_adr_d;
    end
  end

`ifdef DMG_CLKMON_MCNT_EN
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (state_d == S_IDLE) begin
      mcnt_d = '0;
    end else if (eval && good && (state_q == S_LOCK)) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

  assign MCYCLE_CNT = mcnt_q;
`else
  assign MCYCLE_CNT = '0;
`endif

  assign LOCKED     = locked_q;
  assign T_STATE    = t_state_q;
  assign ERR_PERIOD = err_period_q;
  assign ERR_DATA   = err_data_q;
  assign ERR_INC    = err_inc_q;
  assign ERR_ADR    = err_adr_q;

endmodule

`default_nettype wire

// File: tb/tb_dmg_clk_phase_monitor.sv
// ============================================================================
// tb_dmg_clk_phase_monitor: directed scoreboard bench for dmg_clk_phase_monitor.
// Expected counter values follow DMG_CLKMON_MCNT_EN.                Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmg_clk_phase_monitor;

  localparam int CW = 4;
`ifdef DMG_CLKMON_MCNT_EN
  localparam bit MCNT_ON = 1'b1;
`else
  localparam bit MCNT_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          MAIN_CLK_P = 1'b0, DATA_CLK_P = 1'b0, INC_CLK_P = 1'b0;
  logic          ADR_CLK_P = 1'b0, ADR_CLK_N = 1'b1;
  logic          CLK_ENA = 1'b0, OSC_STABLE = 1'b0, SYNC_RESET = 1'b0, ERR_CLR = 1'b0;
  logic          LOCKED;
  logic [1:0]    T_STATE;
  logic          ERR_PERIOD, ERR_DATA, ERR_INC, ERR_ADR;
  logic [CW-1:0] MCYCLE_CNT;

  dmg_clk_phase_monitor #(
    .MCYCLE_LEN (4),
    .LOCK_CYCLES(2),
    .CNT_W      (CW)
  ) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .MAIN_CLK_P(MAIN_CLK_P),
    .DATA_CLK_P(DATA_CLK_P),
    .INC_CLK_P (INC_CLK_P),
    .ADR_CLK_P (ADR_CLK_P),
    .ADR_CLK_N (ADR_CLK_N),
    .CLK_ENA   (CLK_ENA),
    .OSC_STABLE(OSC_STABLE),
    .SYNC_RESET(SYNC_RESET),
    .ERR_CLR   (ERR_CLR),
    .LOCKED    (LOCKED),
    .T_STATE   (T_STATE),
    .ERR_PERIOD(ERR_PERIOD),
    .ERR_DATA  (ERR_DATA),
    .ERR_INC   (ERR_INC),
    .ERR_ADR   (ERR_ADR),
    .MCYCLE_CNT(MCYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    logic          lk;
    logic [1:0]    t;
    logic [3:0]    fl;   // {ADR, INC, DATA, PERIOD}
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t  eq[$];
  string nq[$];

  function automatic logic [CW-1:0] ec(input int n);
    return MCNT_ON ? CW'(n) : '0;
  endfunction

  // Expectation for the outputs produced by the next rising edge.
  task automatic push_exp(input string nm, input logic lk, input logic [1:0] t,
                          input logic [3:0] fl, input logic [CW-1:0] cnt);
    exp_t e;
    e.cyc = edge_n + 1;
    e.lk  = lk;
    e.t   = t;
    e.fl  = fl;
    e.cnt = cnt;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic drive(input logic m, input logic d, input logic i, input logic ap,
                       input logic an, input logic ena, input logic osc,
                       input logic sr, input logic clr);
    @(negedge CLK);
    MAIN_CLK_P = m;  DATA_CLK_P = d;  INC_CLK_P = i;
    ADR_CLK_P  = ap; ADR_CLK_N  = an; CLK_ENA   = ena;
    OSC_STABLE = osc; SYNC_RESET = sr; ERR_CLR  = clr;
  endtask

  // One M-cycle: MAIN high on samples 0-1, DATA pulse on 1, INC pulse on 3.
  // lk/fl/cnt are the hand-derived outputs after this cycle's MAIN rise.
  task automatic mcycle(input int len, input int nd, input int ni, input int adr_at,
                        input int clr_at, input int frz_at, input logic lk,
                        input logic [3:0] fl, input int cnt, input string nm);
    logic [3:0] cur;
    cur = fl;
    for (int i = 0; i < len; i++) begin
      logic m, d, n, f, c;
      m = (i < 2);
      d = (nd >= 1 && i == 1) || (nd >= 2 && i == 3);
      n = (ni >= 1 && i == 3) || (ni >= 2 && i == 1);
      f = (i == adr_at);
      c = (i == clr_at);
      if (i == 0)  cur = fl;
      else if (c)  cur = f ? 4'b1000 : 4'b0000;
      else if (f)  cur = cur | 4'b1000;
      drive(m, d, n, f, 1'b1, 1'b1, 1'b1, 1'b0, c);
      push_exp($sformatf("%s_s%0d", nm, i), lk, lk ? 2'(i) : 2'd0, cur, ec(cnt));
      if (i == frz_at) begin
        for (int k = 0; k < 10; k++) begin
          drive(m, d, n, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
          push_exp($sformatf("%s_frz%0d", nm, k), lk, lk ? 2'(i) : 2'd0, cur, ec(cnt));
        end
      end
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t  e;
    string nm;
    logic [3:0] act_fl;
    while (eq.size() > 0 && eq[0].cyc <= edge_n) begin
      e  = eq.pop_front();
      nm = nq.pop_front();
      act_fl = {ERR_ADR, ERR_INC, ERR_DATA, ERR_PERIOD};
      checks++;
      if (e.cyc != edge_n || LOCKED !== e.lk || T_STATE !== e.t ||
          act_fl !== e.fl || MCYCLE_CNT !== e.cnt) begin
        errors++;
        $display("FAIL %s edge %0d: got lk=%b t=%0d flags=%b cnt=%0d, want lk=%b t=%0d flags=%b cnt=%0d (due edge %0d)",
                 nm, edge_n, LOCKED, T_STATE, act_fl, MCYCLE_CNT,
                 e.lk, e.t, e.fl, e.cnt, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random activity on every input.
    for (int k = 0; k < 4; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      push_exp("reset", 1'b0, 2'd0, 4'b0000, '0);
    end

    // Released with the oscillator unstable: must stay idle.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      nRESET = 1'b1;
      push_exp("osc_low", 1'b0, 2'd0, 4'b0000, '0);
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp("acq_entry", 1'b0, 2'd0, 4'b0000, '0);

    //     len nd ni adr clr frz lk    flags    cnt
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b0000, 0, "c1_acq");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b0000, 0, "c2_sync");
    mcycle(4, 1, 1, -1, -1, -1, 1'b1, 4'b0000, 0, "c3_lock");
    mcycle(4, 1, 1, -1, -1, -1, 1'b1, 4'b0000, 1, "c4_locked");
    mcycle(5, 1, 1, -1, -1, -1, 1'b1, 4'b0000, 2, "c5_stretch");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b0001, 2, "c6_unlock");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b0001, 2, "c7_sync");
    mcycle(4, 1, 1, -1, -1, -1, 1'b1, 4'b0001, 2, "c8_relock");
    mcycle(4, 0, 1, -1,  2, -1, 1'b1, 4'b0001, 3, "c9_nodata");
    mcycle(4, 1, 2, -1, -1, -1, 1'b0, 4'b0010, 3, "c10_dblinc");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b0110, 3, "c11_sync");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b0110, 3, "c12_sync");
    mcycle(4, 1, 1,  2,  2, -1, 1'b1, 4'b0110, 3, "c13_adr_clr");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b1000, 3, "c14_unlock");
    mcycle(4, 1, 1, -1, -1, -1, 1'b0, 4'b1000, 3, "c15_sync");
    mcycle(4, 1, 1, -1, -1,  2, 1'b1, 4'b1000, 3, "c16_freeze");
    for (int n = 17; n <= 30; n++) begin
      mcycle(4, 1, 1, -1, -1, -1, 1'b1, 4'b1000, n - 13, $sformatf("c%0d_count", n));
    end

    // Oscillator loss forces idle, drops lock and clears the counter.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      push_exp("osc_lost", 1'b0, 2'd0, 4'b1000, '0);
    end

    for (int k = 0; k < 10 && eq.size() > 0; k++) @(negedge CLK);
    @(negedge CLK);
    if (eq.size() > 0) begin
      errors += eq.size();
      $display("FAIL drain: got %0d pending expectations, want 0", eq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
